// File: rtl/mips32_memory_responder_if.sv
// rtl/mips32_memory_responder_if.sv - core memory port and host program-load port bundle
interface mips32_memory_responder_if #(
    parameter int WIDTH = 32
);
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] memdata;

    logic             host_start;
    logic             host_valid;
    logic [WIDTH-1:0] host_data;
    logic             host_last;
    logic             host_ready;

    modport master (
        output memread, memwrite, adr, writedata,
        output host_start, host_valid, host_data, host_last,
        input  memdata, host_ready
    );

    modport slave (
        input  memread, memwrite, adr, writedata,
        input  host_start, host_valid, host_data, host_last,
        output memdata, host_ready
    );
endinterface

// File: rtl/mips32_memory_responder.sv
// rtl/mips32_memory_responder.sv - word RAM, output register and host loader for the mips32 core
module mips32_memory_responder #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 256,
    parameter logic [WIDTH-1:0] IO_ADDR = 32'hFFFF_FFFC
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    mips32_memory_responder_if.slave    bus,
    output logic                        o_cpu_reset,
    output logic [WIDTH-1:0]            o_io_out,
    output logic                        o_io_valid,
    output logic                        o_load_err,
    output logic                        o_addr_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADING,
        S_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_ptr;
    logic             r_discard;
    logic             r_cpu_reset;
    logic [WIDTH-1:0] r_io_out;
    logic             r_io_valid;
    logic             r_load_err;
    logic             r_addr_err;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_run;
    logic             w_loading;
    logic             w_host_fire;
    logic             w_host_wr;
    logic             w_overflow;
    logic [AW-1:0]    w_index;
    logic             w_in_range;
    logic             w_is_io;
    logic             w_misaligned;
    logic             w_core_wr;
    logic             w_io_wr;
    logic             w_addr_err_set;
    logic             w_host_ready;

    assign w_run        = (r_state == S_RUN);
    assign w_loading    = (r_state == S_LOADING);
    assign w_host_fire  = w_loading & bus.host_valid;
    assign w_host_wr    = w_host_fire & ~r_discard & ~i_reset;
    // The word that lands in the last slot without host_last is the overflow point.
    assign w_overflow   = w_host_fire & ~bus.host_last & ~r_discard & (r_ptr == AW'(DEPTH - 1));

    assign w_index      = bus.adr[AW+1:2];
    assign w_in_range   = (bus.adr[WIDTH-1:AW+2] == '0);
    assign w_is_io      = (bus.adr == IO_ADDR);
    assign w_misaligned = (bus.adr[1:0] != 2'b00);
    assign w_io_wr      = w_run & bus.memwrite & w_is_io;
    assign w_core_wr    = w_run & bus.memwrite & ~w_is_io & w_in_range & ~i_reset;

    assign w_addr_err_set = w_run & (((bus.memread | bus.memwrite) & w_misaligned)
                                   | (bus.memread & ~w_in_range)
                                   | (bus.memwrite & ~w_is_io & ~w_in_range));

    assign bus.memdata  = (w_run && bus.memread && w_in_range) ? r_mem[w_index] : '0;
    assign bus.host_ready = w_host_ready;

    always_comb begin
        w_state_next = r_state;
        w_host_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.host_start) w_state_next = S_LOADING;
            end
            S_LOADING: begin
                w_host_ready = 1'b1;
                if (bus.host_valid && bus.host_last) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (bus.host_start) w_state_next = S_LOADING;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_discard   <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_io_out    <= '0;
            r_io_valid  <= 1'b0;
            r_load_err  <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_reset <= (w_state_next != S_RUN);
            r_io_valid  <= w_io_wr;
            if (w_io_wr) r_io_out <= bus.writedata;
            if (!w_loading && bus.host_start) begin
                r_ptr     <= '0;
                r_discard <= 1'b0;
            end else if (w_host_fire && !r_discard) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_overflow) begin
                r_discard  <= 1'b1;
                r_load_err <= 1'b1;
            end
            if (w_addr_err_set) r_addr_err <= 1'b1;
        end
    end

    // Host and core writes never overlap: the host only writes in LOADING, the core only in RUN.
    always_ff @(posedge i_clk) begin
        if (w_host_wr) begin
            r_mem[r_ptr] <= bus.host_data;
        end else if (w_core_wr) begin
            r_mem[w_index] <= bus.writedata;
        end
    end

    assign o_cpu_reset = r_cpu_reset;
    assign o_io_out    = r_io_out;
    assign o_io_valid  = r_io_valid;
    assign o_load_err  = r_load_err;
    assign o_addr_err  = r_addr_err;
endmodule

// File: tb/tb_mips32_memory_responder.sv
// tb/tb_mips32_memory_responder.sv - scoreboard bench for mips32_memory_responder
module tb_mips32_memory_responder;
    localparam int          DEPTH   = 256;
    localparam logic [31:0] IO_ADDR = 32'hFFFF_FFFC;

    localparam int K_MEMDATA   = 0;
    localparam int K_CPU_RESET = 1;
    localparam int K_READY     = 2;
    localparam int K_LOAD_ERR  = 3;
    localparam int K_ADDR_ERR  = 4;
    localparam int K_IO_OUT    = 5;
    localparam int K_IO_VALID  = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_reset;
    logic [31:0] io_out;
    logic        io_valid;
    logic        load_err;
    logic        addr_err;
    logic        mon_en = 1'b0;

    int          checks = 0;
    int          errors = 0;
    exp_t        q_sample[$];
    logic [31:0] q_io[$];
    logic [31:0] prog [3];

    mips32_memory_responder_if #(.WIDTH(32)) bus ();

    mips32_memory_responder #(
        .WIDTH(32), .DEPTH(DEPTH), .IO_ADDR(IO_ADDR)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .bus(bus),
        .o_cpu_reset(cpu_reset),
        .o_io_out(io_out),
        .o_io_valid(io_valid),
        .o_load_err(load_err),
        .o_addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string name, input int kind, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        q_sample.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.adr        = '0;
        bus.writedata  = '0;
        bus.host_start = 1'b0;
        bus.host_valid = 1'b0;
        bus.host_data  = '0;
        bus.host_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (q_sample.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = q_sample.pop_front();
                case (e.kind)
                    K_MEMDATA:   act = bus.memdata;
                    K_CPU_RESET: act = {31'd0, cpu_reset};
                    K_READY:     act = {31'd0, bus.host_ready};
                    K_LOAD_ERR:  act = {31'd0, load_err};
                    K_ADDR_ERR:  act = {31'd0, addr_err};
                    K_IO_OUT:    act = io_out;
                    default:     act = {31'd0, io_valid};
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
            if (io_valid === 1'b1) begin
                checks++;
                if (q_io.size() == 0) begin
                    errors++;
                    $display("FAIL io_valid_unexpected: got 1 expected 0 (io_out=%h)", io_out);
                end else begin
                    logic [31:0] v;
                    v = q_io.pop_front();
                    if (io_out !== v) begin
                        errors++;
                        $display("FAIL io_out_on_valid: got %h expected %h", io_out, v);
                    end
                end
            end
        end
    end

    initial begin
        prog[0] = 32'h2002_0005;
        prog[1] = 32'hAC02_0000;
        prog[2] = 32'h0800_0002;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        expect_val("rst_cpu_reset", K_CPU_RESET, 32'd1);
        expect_val("rst_host_ready", K_READY, 32'd0);
        expect_val("rst_load_err", K_LOAD_ERR, 32'd0);
        expect_val("rst_addr_err", K_ADDR_ERR, 32'd0);
        expect_val("rst_io_out", K_IO_OUT, 32'd0);
        expect_val("rst_io_valid", K_IO_VALID, 32'd0);
        tick();

        // Load a 3-word program while core strobes (ignored) are active.
        bus.host_start = 1'b1;
        expect_val("idle_host_ready", K_READY, 32'd0);
        tick();
        bus.host_start = 1'b0;
        bus.memread    = 1'b1;
        bus.memwrite   = 1'b1;
        bus.adr        = IO_ADDR;
        bus.writedata  = 32'h0000_0BAD;
        for (int i = 0; i < 3; i++) begin
            bus.host_valid = 1'b1;
            bus.host_data  = prog[i];
            bus.host_last  = (i == 2);
            expect_val("load_host_ready", K_READY, 32'd1);
            expect_val("load_cpu_reset", K_CPU_RESET, 32'd1);
            expect_val("load_memdata_zero", K_MEMDATA, 32'd0);
            tick();
        end
        clear_inputs();
        expect_val("run_cpu_reset", K_CPU_RESET, 32'd0);
        expect_val("run_host_ready", K_READY, 32'd0);
        expect_val("load_strobes_no_err", K_ADDR_ERR, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.memread = 1'b1;
            bus.adr     = 32'(i * 4);
            expect_val("prog_readback", K_MEMDATA, prog[i]);
            tick();
        end
        bus.memread = 1'b0;
        bus.adr     = 32'h4;
        expect_val("no_memread_zero", K_MEMDATA, 32'd0);
        tick();

        // Output register write must not touch RAM.
        bus.memwrite  = 1'b1;
        bus.adr       = 32'h0000_03FC;
        bus.writedata = 32'hCAFE_F00D;
        tick();
        bus.adr       = IO_ADDR;
        bus.writedata = 32'h1234_5678;
        q_io.push_back(32'h1234_5678);
        tick();
        bus.memwrite = 1'b0;
        bus.adr      = '0;
        tick();
        expect_val("io_out_hold", K_IO_OUT, 32'h1234_5678);
        expect_val("io_valid_one_cycle", K_IO_VALID, 32'd0);
        bus.memread = 1'b1;
        bus.adr     = 32'h0000_03FC;
        expect_val("io_ram_unchanged", K_MEMDATA, 32'hCAFE_F00D);
        expect_val("io_no_addr_err", K_ADDR_ERR, 32'd0);
        tick();

        // Out-of-range write, then misaligned and out-of-range reads.
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b1;
        bus.adr       = 32'h0000_1000;
        bus.writedata = 32'hDEAD_BEEF;
        tick();
        bus.memwrite = 1'b0;
        bus.memread  = 1'b1;
        bus.adr      = 32'h2;
        expect_val("oor_write_err", K_ADDR_ERR, 32'd1);
        expect_val("misaligned_read_data", K_MEMDATA, prog[0]);
        tick();
        bus.adr = 32'h0000_1000;
        expect_val("addr_err_sticky", K_ADDR_ERR, 32'd1);
        expect_val("oor_read_zero", K_MEMDATA, 32'd0);
        tick();

        // Simultaneous read and write: old data now, new data next cycle.
        bus.memwrite  = 1'b1;
        bus.adr       = 32'h8;
        bus.writedata = 32'h5555_5555;
        expect_val("rw_pre_write", K_MEMDATA, prog[2]);
        tick();
        bus.memwrite = 1'b0;
        expect_val("rw_post_write", K_MEMDATA, 32'h5555_5555);
        tick();

        // Overflowing load of DEPTH+2 words, started from RUN.
        clear_inputs();
        bus.host_start = 1'b1;
        tick();
        bus.host_start = 1'b0;
        expect_val("reload_cpu_reset", K_CPU_RESET, 32'd1);
        expect_val("reload_host_ready", K_READY, 32'd1);
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus.host_valid = 1'b1;
            bus.host_data  = 32'hA000_0000 + 32'(i);
            bus.host_last  = (i == DEPTH + 1);
            if (i == DEPTH - 1) expect_val("no_load_err_yet", K_LOAD_ERR, 32'd0);
            if (i == DEPTH) expect_val("load_err_set", K_LOAD_ERR, 32'd1);
            tick();
        end
        clear_inputs();
        expect_val("ovf_run_entered", K_CPU_RESET, 32'd0);
        expect_val("ovf_load_err_sticky", K_LOAD_ERR, 32'd1);
        bus.memread = 1'b1;
        bus.adr     = 32'h0;
        expect_val("ovf_mem0", K_MEMDATA, 32'hA000_0000);
        tick();
        bus.adr = 32'h4;
        expect_val("ovf_no_wrap_mem1", K_MEMDATA, 32'hA000_0001);
        tick();
        bus.adr = 32'h0000_03FC;
        expect_val("ovf_mem_last", K_MEMDATA, 32'hA000_00FF);
        tick();

        // Reset after two of four handshakes; a word offered during reset is dropped.
        clear_inputs();
        bus.host_start = 1'b1;
        tick();
        bus.host_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.host_valid = 1'b1;
            bus.host_data  = (i == 0) ? 32'h1111_1111 : 32'h2222_2222;
            tick();
        end
        bus.host_data = 32'h3333_3333;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        expect_val("midrst_cpu_reset", K_CPU_RESET, 32'd1);
        expect_val("midrst_host_ready", K_READY, 32'd0);
        expect_val("midrst_load_err_clr", K_LOAD_ERR, 32'd0);
        expect_val("midrst_addr_err_clr", K_ADDR_ERR, 32'd0);
        tick();
        bus.host_start = 1'b1;
        tick();
        bus.host_start = 1'b0;
        bus.host_valid = 1'b1;
        bus.host_data  = 32'h4444_4444;
        bus.host_last  = 1'b1;
        tick();
        clear_inputs();
        bus.memread = 1'b1;
        bus.adr     = 32'h4;
        expect_val("midrst_mem1_kept", K_MEMDATA, 32'h2222_2222);
        tick();
        bus.adr = 32'h8;
        expect_val("midrst_reset_blocks_write", K_MEMDATA, 32'hA000_0002);
        tick();
        bus.adr = 32'h0;
        expect_val("reload_mem0", K_MEMDATA, 32'h4444_4444);
        tick();
        bus.adr = 32'h6;
        expect_val("misaligned_word_index", K_MEMDATA, 32'h2222_2222);
        expect_val("pre_misalign_no_err", K_ADDR_ERR, 32'd0);
        tick();
        bus.memread = 1'b0;
        expect_val("misaligned_sets_err", K_ADDR_ERR, 32'd1);
        tick();
        tick();

        checks++;
        if (q_io.size() != 0) begin
            errors++;
            $display("FAIL io_valid_missing: got %0d pending expected 0", q_io.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
